// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- receive half of the debug UART (8N1, LSB first).
//
// The asynchronous rx line is brought into the clk domain through a two-flop
// synchronizer and over-sampled with a tick counter. Each byte is recovered
// by sampling at mid-bit. A completed byte is handed to a one-entry holding
// register that is read through a valid/ready stream.
//
// Parameters
//   CLK_FREQ_HZ    clk frequency in Hz (must be overridden)
//   BAUD_RATE      line rate in baud (must be overridden)
//                  TICKS_PER_BIT = floor(CLK_FREQ_HZ / BAUD_RATE)
//
// Ports
//   clk             in   1  sole clock
//   rst_n           in   1  asynchronous, active-low reset
//   bit_in          in   1  raw serial line, async to clk, idles high
//   byte_out_data   out  8  received byte, stable while byte_out_valid=1
//   byte_out_valid  out  1  holding register full
//   byte_out_ready  in   1  consumer accepts on valid && ready
//   frame_err       out  1  one-cycle pulse: stop bit sampled low
//   overrun         out  1  one-cycle pulse: byte completed while holding full
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 0,
  parameter int unsigned BAUD_RATE   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  output logic [7:0] byte_out_data,
  output logic       byte_out_valid,
  input  logic       byte_out_ready,
  output logic       frame_err,
  output logic       overrun
);

  // The divisor is guarded so an unset BAUD_RATE does not divide by zero
  // during elaboration; the clamp to 2 keeps the half-bit compare value
  // non-negative. Neither guard yields a usable receiver -- both
  // parameters still have to be set by the instantiating design.
  localparam int unsigned TPB_RAW =
    CLK_FREQ_HZ / ((BAUD_RATE == 0) ? 1 : BAUD_RATE);
  localparam int unsigned TICKS_PER_BIT = (TPB_RAW < 2) ? 2 : TPB_RAW;
  localparam int unsigned CNT_W         = $clog2(TICKS_PER_BIT) + 1;

  // Start bit is confirmed half a bit after the falling edge; every later
  // sample is a full bit after the previous one, landing at mid-bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TICKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic             sync1_q;
  logic             rx_s_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic             armed_q;
  logic [7:0]       shreg_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;

  logic             sample_d;
  logic             load_ok_d;

  // Mid-bit sample strobe shared by DATA and STOP.
  assign sample_d  = (cnt_q == CNT_FULL);

  // The holding register can take a new byte when empty or when its current
  // byte is being accepted on this very edge.
  assign load_ok_d = !valid_q || byte_out_ready;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Resets to the idle (high) line level so that a
  // reset release never looks like a start edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bit_in;
      rx_s_q  <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Data shift register. Pure datapath: no reset, because all eight bits are
  // overwritten before any of them can reach the holding register.
  // Right shift so the LSB, which arrives first, ends up in bit 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && sample_d) begin
      shreg_q <= {rx_s_q, shreg_q[7:1]};
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM, holding register and status pulses.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;

      // Accept empties the holding register; a load later in this block
      // overrides it so accept+load keeps valid high with the new byte.
      if (valid_q && byte_out_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          // Arming requires seeing the line high, so a held-low line (break
          // or stuck wire) after a framing error cannot retrigger reception.
          if (rx_s_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // Line back high at mid-start means a glitch, not a frame.
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (sample_d) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          // Leaving at mid-stop gives half a bit of slack for the next
          // start edge of a back-to-back frame.
          if (sample_d) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (rx_s_q) begin
              if (load_ok_d) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
              end else begin
                // New byte is dropped; the held byte stays untouched.
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              armed_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign byte_out_data  = data_q;
  assign byte_out_valid = valid_q;
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int T      = CLK_HZ / BAUD;   // clocks per serial bit

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bit_in        (bit_in),
    .byte_out_data (data),
    .byte_out_valid(valid),
    .byte_out_ready(ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer ready: either commanded by the directed sequence or random.
  logic ready_cmd = 1'b1;
  bit   rnd_ready = 1'b0;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  // Stream monitor: collects accepted bytes, counts pulse cycles and checks
  // that a byte being held back by ready=0 does not change.
  logic [7:0] got[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_data", 32'(data), 32'(prev_data));
      end
      if (valid && ready) got.push_back(data);
      fe_cnt += int'(frame_err);
      ov_cnt += int'(overrun);
    end
    prev_hold = rst_n && valid && !ready;
    prev_data = data;
  end

  // Line driving: all changes happen 1 time unit after a rising edge.
  task automatic hold(input logic b, input int n);
    bit_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, T);
    for (int i = 0; i < 8; i++) hold(b[i], T);
    hold(stop_bit, T);
  endtask

  task automatic clear_obs();
    got.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic compare_stream(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp[$];
    logic [7:0] b;

    // Reset state
    rst_n  = 1'b0;
    bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // 1) single byte, consumer ready
    clear_obs();
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 20);
    exp = '{8'hA5};
    compare_stream("s1", exp);
    check("s1_frame_err", 32'(fe_cnt), 32'd0);
    check("s1_overrun", 32'(ov_cnt), 32'd0);

    // 2) short low glitch is ignored, following frame still received
    clear_obs();
    hold(1'b0, 3);
    hold(1'b1, 30);
    check("s2_glitch_count", 32'(got.size()), 32'd0);
    check("s2_glitch_ferr", 32'(fe_cnt), 32'd0);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 20);
    exp = '{8'h3C};
    compare_stream("s2", exp);
    check("s2_frame_err", 32'(fe_cnt), 32'd0);

    // 3) bad stop bit, then line held low: one error, nothing delivered
    clear_obs();
    send_frame(8'h81, 1'b0);
    hold(1'b0, 50);
    hold(1'b1, 40);
    check("s3_frame_err", 32'(fe_cnt), 32'd1);
    check("s3_count", 32'(got.size()), 32'd0);
    check("s3_overrun", 32'(ov_cnt), 32'd0);

    // 4) consumer stalled: first byte held, second causes overrun
    ready_cmd = 1'b0;
    hold(1'b1, 5);
    clear_obs();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 20);
    check("s4_valid_held", 32'(valid), 32'd1);
    check("s4_data_held", 32'(data), 32'h11);
    check("s4_overrun", 32'(ov_cnt), 32'd1);
    check("s4_none_taken", 32'(got.size()), 32'd0);
    ready_cmd = 1'b1;
    hold(1'b1, 5);
    exp = '{8'h11};
    compare_stream("s4", exp);
    check("s4_valid_drop", 32'(valid), 32'd0);
    check("s4_frame_err", 32'(fe_cnt), 32'd0);

    // 5) back-to-back frames without idle time
    clear_obs();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    hold(1'b1, 20);
    exp = '{8'h00, 8'hFF, 8'h55};
    compare_stream("s5", exp);
    check("s5_frame_err", 32'(fe_cnt), 32'd0);
    check("s5_overrun", 32'(ov_cnt), 32'd0);

    // 6) reset during bit 4 aborts the frame silently
    clear_obs();
    b = 8'h6B;
    hold(1'b0, T);
    for (int i = 0; i < 4; i++) hold(b[i], T);
    hold(b[4], 4);
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid", 32'(valid), 32'd0);
    check("s6_rst_data", 32'(data), 32'd0);
    check("s6_rst_ferr", 32'(frame_err), 32'd0);
    bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 30);
    check("s6_aborted_count", 32'(got.size()), 32'd0);
    check("s6_aborted_ferr", 32'(fe_cnt), 32'd0);
    send_frame(8'h6B, 1'b1);
    hold(1'b1, 20);
    exp = '{8'h6B};
    compare_stream("s6", exp);
    check("s6_frame_err", 32'(fe_cnt), 32'd0);
    check("s6_overrun", 32'(ov_cnt), 32'd0);

    // Random bytes with a randomly stalling consumer; each byte is drained
    // before the next frame so none may be lost.
    clear_obs();
    exp.delete();
    rnd_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      exp.push_back(b);
      send_frame(b, 1'b1);
      hold(1'b1, $urandom_range(0, 20));
      wait_beats(n + 1, 200);
    end
    rnd_ready = 1'b0;
    ready_cmd = 1'b1;
    hold(1'b1, 5);
    compare_stream("rnd", exp);
    check("rnd_frame_err", 32'(fe_cnt), 32'd0);
    check("rnd_overrun", 32'(ov_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
